ppu_bg_fetch: RTL and testbench
===============================

# ppu_bg_fetch

PPU-side background tile fetch sequencer. It issues the nametable, attribute and pattern read requests to the PPU port of `memory_manager_top` and captures the returned bytes. It also maintains the background pattern/attribute shift registers and produces one 4-bit background pixel per dot. It is the requesting end of the `ppu_addr` / `ppu_read_request` / `ppu_data_out` interface.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: clk cycles from the request cycle to valid data on `mem_data_in`. Range 1–3.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `dot_tick`, in, 1: one-clk pixel-dot enable.
- `fetch_en`, in, 1: rendering enabled and the current dot is in the fetch region.
- `v_addr`, in, 15: loopy v. Fields are [4:0] coarse X, [9:5] coarse Y, [11:10] NT select, [14:12] fine Y.
- `bg_pt_sel`, in, 1: background pattern table select (PPUCTRL bit 4).
- `fine_x`, in, 3: fine X scroll.
- `mem_addr`, out, 14: to `ppu_addr`.
- `mem_read_request`, out, 1: to `ppu_read_request`.
- `mem_wr_request`, out, 1: to `ppu_wr_request`. Constant 0.
- `mem_data_in`, in, 8: from `ppu_data_out`.
- `tile_done`, out, 1: one-clk pulse after the pattern-high byte is captured. Increments coarse X externally.
- `bg_pixel`, out, 4: {attr[1:0], pattern_hi, pattern_lo}.
- `overrun`, out, 1: sticky; a `dot_tick` arrived while a read was outstanding.

## Operation
- 3-bit `phase` counter. It advances on `dot_tick` when `fetch_en`=1. It wraps 7→0.
- Fetch issued on the `dot_tick` that enters each odd phase:
  - Phase 1, NT: `mem_addr` = 0x2000 | v[11:0].
  - Phase 3, AT: `mem_addr` = 0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2].
  - Phase 5, PT low: `mem_addr` = bg_pt_sel<<12 | tile_id<<4 | 0 | v[14:12].
  - Phase 7, PT high: same as PT low but with bit 3 = 1.
- Request FSM:
  - IDLE: on a fetch dot, drive `mem_addr` and assert `mem_read_request` for one clk, then go to WAIT.
  - WAIT: count MEM_LATENCY clks, capture `mem_data_in` into the latch for the current phase, then go to IDLE.
  - `mem_addr` holds its value through WAIT.
- Latches:
  - `tile_id` ← NT byte.
  - `at_bits` ← (AT byte >> {v[6],v[1],1'b0}) & 3.
  - `pt_lo` ← PT low byte.
  - `pt_hi` ← PT high byte.
- Reload: on the `dot_tick` where phase goes 7→0, load `pt_lo`/`pt_hi` into bits [7:0] of the 16-bit pattern shift registers. Load replicated `at_bits` into the 8-bit attribute shifters.
- Shift: every `dot_tick` with `fetch_en`=1, all shifters shift left by one. Reload takes priority over shift for the low byte; the high byte still shifts.
- `bg_pixel` is registered on `dot_tick` as {at_hi[7-fine_x], at_lo[7-fine_x], pshift_hi[15-fine_x], pshift_lo[15-fine_x]}.

## Timing
- Reset values: `phase`=0, FSM=IDLE, `mem_addr`=0, `mem_read_request`=0, all latches and shifters 0, `bg_pixel`=0, `tile_done`=0, `overrun`=0.
- Request is asserted in the clk of the `dot_tick`, registered, so it is visible one clk later. Data is sampled exactly MEM_LATENCY clks after `mem_read_request` is first high.
- `tile_done` pulses in the clk after the PT-high capture.
- `dot_tick` spacing must be ≥ MEM_LATENCY+2 clks. A `dot_tick` during WAIT sets `overrun`, which is cleared only by reset. The outstanding capture still completes, and the new fetch is dropped.
- `fetch_en` falls mid-tile: `phase` is forced to 0, an outstanding capture completes, and there is no reload and no `tile_done`. Shifters hold.
- `rst` low mid-WAIT: return to the reset state in the next clk. `mem_read_request` is 0 the same cycle `rst` is sampled.
- `v_addr` is sampled only on request dots. External changes between fetches are ignored.

## Structure
- Package `ppu_pkg` holds:
  - Address-base constants: NT_BASE 0x2000, AT_OFFSET 0x3C0, PT_PLANE_HI 0x8.
  - The FSM state encoding: IDLE, WAIT.
  - The v_addr field indices.
- Sub-module `ppu_bg_shifter` holds the pattern/attribute shift registers, reload, and fine-X mux. The fetch FSM, phase counter and address generation stay in the top level.

## Test plan
- Reset, then v=0x0000, bg_pt_sel=0, MEM_LATENCY=1, NT model returns 0x24 → requests 0x2000, 0x23C0, 0x0240, 0x0248 on phases 1, 3, 5, 7. One `tile_done` pulse.
- v=0x0C63 (NT3, coarse X=3, coarse Y=3) → AT request 0x2FC0, and the quadrant shift is 6. AT byte 0xC0 gives `at_bits`=3.
- PT low=0xAA, PT high=0xFF, fine_x=0 → after reload, `bg_pixel` alternates 0x3/0x2 (with at_bits=0) over 8 dots. With fine_x=1, the sequence starts with 0x2.
- `dot_tick` spaced 2 clks with MEM_LATENCY=1 → `overrun`=1 stays set, and the NT capture is still correct.
- `fetch_en` dropped at phase 4 → no PT requests, no `tile_done`. After re-enable, fetching restarts with the NT fetch at phase 1.
- `rst`=0 asserted during WAIT → next clk `mem_read_request`=0, `bg_pixel`=0, phase=0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared constants, state encodings and address helpers for the PPU background fetch path.
package ppu_pkg;

    localparam logic [13:0] NT_BASE     = 14'h2000;
    localparam logic [13:0] AT_OFFSET   = 14'h03C0;
    localparam logic [13:0] PT_PLANE_HI = 14'h0008;

    // loopy v field positions
    localparam int V_CX_LSB = 0;
    localparam int V_CX_MSB = 4;
    localparam int V_CY_LSB = 5;
    localparam int V_CY_MSB = 9;
    localparam int V_NT_LSB = 10;
    localparam int V_NT_MSB = 11;
    localparam int V_FY_LSB = 12;
    localparam int V_FY_MSB = 14;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_t;

    // Encoding matches phase[2:1] of the dot that issues the fetch.
    typedef enum logic [1:0] {
        FK_NT    = 2'd0,
        FK_AT    = 2'd1,
        FK_PT_LO = 2'd2,
        FK_PT_HI = 2'd3
    } fetch_kind_t;

    function automatic logic [13:0] nt_addr(input logic [11:0] nt_cy_cx);
        return NT_BASE | {2'b00, nt_cy_cx};
    endfunction

    function automatic logic [13:0] at_addr(input logic [1:0] nt_sel,
                                            input logic [2:0] cy_hi,
                                            input logic [2:0] cx_hi);
        return NT_BASE | AT_OFFSET | {2'b00, nt_sel, 4'b0000, cy_hi, cx_hi};
    endfunction

    function automatic logic [13:0] pt_addr(input logic       pt_sel,
                                            input logic [7:0] tile,
                                            input logic [2:0] fine_y,
                                            input logic       plane_hi);
        return {1'b0, pt_sel, tile, 1'b0, fine_y} | (plane_hi ? PT_PLANE_HI : 14'h0000);
    endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// Background pattern/attribute shift registers with tile reload and fine-X pixel select.
module ppu_bg_shifter
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_tick,
    input  logic       shift_en,
    input  logic       reload,
    input  logic [7:0] pt_lo,
    input  logic [7:0] pt_hi,
    input  logic [1:0] at_bits,
    input  logic [2:0] fine_x,
    output logic [3:0] bg_pixel
);

    logic [15:0] pshift_lo;
    logic [15:0] pshift_hi;
    logic [7:0]  at_lo;
    logic [7:0]  at_hi;
    logic [2:0]  at_idx;
    logic [3:0]  pt_idx;
    logic [3:0]  pixel_sel;

    // 7-fine_x and 15-fine_x without widening to 32 bits
    always_comb begin
        at_idx    = ~fine_x;
        pt_idx    = {1'b1, ~fine_x};
        pixel_sel = {at_hi[at_idx], at_lo[at_idx], pshift_hi[pt_idx], pshift_lo[pt_idx]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pshift_lo <= '0;
            pshift_hi <= '0;
            at_lo     <= '0;
            at_hi     <= '0;
            bg_pixel  <= '0;
        end else begin
            if (dot_tick) begin
                bg_pixel <= pixel_sel;
            end
            // Reload replaces the low byte while the high byte keeps shifting.
            if (reload) begin
                pshift_lo <= {pshift_lo[14:7], pt_lo};
                pshift_hi <= {pshift_hi[14:7], pt_hi};
                at_lo     <= {8{at_bits[0]}};
                at_hi     <= {8{at_bits[1]}};
            end else if (shift_en) begin
                pshift_lo <= {pshift_lo[14:0], 1'b0};
                pshift_hi <= {pshift_hi[14:0], 1'b0};
                at_lo     <= {at_lo[6:0], 1'b0};
                at_hi     <= {at_hi[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ppu_bg_fetch.sv
// Background tile fetch sequencer: phase counter, NT/AT/PT request FSM and byte latches.
module ppu_bg_fetch
    import ppu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dot_tick,
    input  logic        fetch_en,
    input  logic [14:0] v_addr,
    input  logic        bg_pt_sel,
    input  logic [2:0]  fine_x,
    output logic [13:0] mem_addr,
    output logic        mem_read_request,
    output logic        mem_wr_request,
    input  logic [7:0]  mem_data_in,
    output logic        tile_done,
    output logic [3:0]  bg_pixel,
    output logic        overrun
);

    localparam logic [1:0] LAT = MEM_LATENCY[1:0];

    fetch_state_t state;
    fetch_kind_t  kind;
    logic [2:0]   phase;
    logic [1:0]   lat_cnt;
    logic [1:0]   at_sel;
    logic [7:0]   tile_id;
    logic [1:0]   at_bits;
    logic [7:0]   pt_lo;
    logic [7:0]   pt_hi;

    logic         shift_en;
    logic         reload;
    logic         fetch_dot;
    logic [13:0]  req_addr;
    logic [1:0]   at_pick;

    assign mem_wr_request = 1'b0;

    always_comb begin
        shift_en  = dot_tick & fetch_en;
        reload    = shift_en & (phase == 3'd7);
        fetch_dot = shift_en & ~phase[0];

        req_addr = '0;
        unique case (phase[2:1])
            2'd0: req_addr = nt_addr(v_addr[V_NT_MSB:0]);
            2'd1: req_addr = at_addr(v_addr[V_NT_MSB:V_NT_LSB],
                                     v_addr[V_CY_MSB:V_CY_MSB-2],
                                     v_addr[V_CX_MSB:V_CX_MSB-2]);
            2'd2: req_addr = pt_addr(bg_pt_sel, tile_id, v_addr[V_FY_MSB:V_FY_LSB], 1'b0);
            2'd3: req_addr = pt_addr(bg_pt_sel, tile_id, v_addr[V_FY_MSB:V_FY_LSB], 1'b1);
        endcase

        // quadrant select {coarse Y bit 1, coarse X bit 1} picks a 2-bit attribute pair
        at_pick = mem_data_in[1:0];
        unique case (at_sel)
            2'd0: at_pick = mem_data_in[1:0];
            2'd1: at_pick = mem_data_in[3:2];
            2'd2: at_pick = mem_data_in[5:4];
            2'd3: at_pick = mem_data_in[7:6];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            kind             <= FK_NT;
            phase            <= '0;
            lat_cnt          <= '0;
            at_sel           <= '0;
            tile_id          <= '0;
            at_bits          <= '0;
            pt_lo            <= '0;
            pt_hi            <= '0;
            mem_addr         <= '0;
            mem_read_request <= 1'b0;
            tile_done        <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so any path that does not set them clears them next clk.
            mem_read_request <= 1'b0;
            tile_done        <= 1'b0;

            if (dot_tick && state == WAIT) begin
                overrun <= 1'b1;
            end

            if (!fetch_en) begin
                phase <= '0;
            end else if (dot_tick) begin
                phase <= phase + 3'd1;
            end

            unique case (state)
                IDLE: begin
                    if (fetch_dot) begin
                        mem_addr         <= req_addr;
                        mem_read_request <= 1'b1;
                        kind             <= fetch_kind_t'(phase[2:1]);
                        at_sel           <= {v_addr[V_CY_LSB+1], v_addr[V_CX_LSB+1]};
                        lat_cnt          <= '0;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT) begin
                        state <= IDLE;
                        unique case (kind)
                            FK_NT:    tile_id <= mem_data_in;
                            FK_AT:    at_bits <= at_pick;
                            FK_PT_LO: pt_lo   <= mem_data_in;
                            FK_PT_HI: begin
                                pt_hi     <= mem_data_in;
                                tile_done <= fetch_en;
                            end
                        endcase
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

    ppu_bg_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .dot_tick (dot_tick),
        .shift_en (shift_en),
        .reload   (reload),
        .pt_lo    (pt_lo),
        .pt_hi    (pt_hi),
        .at_bits  (at_bits),
        .fine_x   (fine_x),
        .bg_pixel (bg_pixel)
    );

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// Directed bench for ppu_bg_fetch with a one-clk-latency memory model and hand-computed vectors.
module tb_ppu_bg_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        dot_tick;
    logic        fetch_en;
    logic [14:0] v_addr;
    logic        bg_pt_sel;
    logic [2:0]  fine_x;
    logic [13:0] mem_addr;
    logic        mem_read_request;
    logic        mem_wr_request;
    logic [7:0]  mem_data_in = 8'h00;
    logic        tile_done;
    logic [3:0]  bg_pixel;
    logic        overrun;

    logic [7:0]  nt_val;
    logic [7:0]  at_val;
    logic [7:0]  ptlo_val;
    logic [7:0]  pthi_val;

    logic [13:0] req_log[$];
    int          td_count = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ppu_bg_fetch #(.MEM_LATENCY(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .dot_tick         (dot_tick),
        .fetch_en         (fetch_en),
        .v_addr           (v_addr),
        .bg_pt_sel        (bg_pt_sel),
        .fine_x           (fine_x),
        .mem_addr         (mem_addr),
        .mem_read_request (mem_read_request),
        .mem_wr_request   (mem_wr_request),
        .mem_data_in      (mem_data_in),
        .tile_done        (tile_done),
        .bg_pixel         (bg_pixel),
        .overrun          (overrun)
    );

    function automatic logic [7:0] mem_model(input logic [13:0] a);
        if (a[13]) return (a[9:6] == 4'hF) ? at_val : nt_val;
        return a[3] ? pthi_val : ptlo_val;
    endfunction

    // data appears one clk after the request is seen
    always @(posedge clk) begin
        if (mem_read_request) mem_data_in <= mem_model(mem_addr);
    end

    always @(negedge clk) begin
        if (mem_read_request) req_log.push_back(mem_addr);
        if (tile_done) td_count++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int idx);
        return (req_log.size() > idx) ? {2'b00, req_log[idx]} : 16'hFFFF;
    endfunction

    // called at a negedge; raises dot_tick for one clk, returns at a negedge gap clks later
    task automatic dot(input int gap);
        dot_tick = 1'b1;
        @(negedge clk);
        dot_tick = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        dot_tick  = 1'b0;
        fetch_en  = 1'b0;
        v_addr    = 15'h0000;
        bg_pt_sel = 1'b0;
        fine_x    = 3'd0;
        nt_val    = 8'h24;
        at_val    = 8'h00;
        ptlo_val  = 8'hAA;
        pthi_val  = 8'hFF;
        repeat (3) @(negedge clk);

        check("rst_addr", {2'b00, mem_addr}, 16'h0000);
        check("rst_req", {15'h0, mem_read_request}, 16'h0000);
        check("rst_pixel", {12'h0, bg_pixel}, 16'h0000);
        check("rst_tile_done", {15'h0, tile_done}, 16'h0000);
        check("rst_overrun", {15'h0, overrun}, 16'h0000);

        rst      = 1'b1;
        fetch_en = 1'b1;
        @(negedge clk);

        // tile 1: v=0, NT byte 0x24
        for (int i = 0; i < 8; i++) dot(4);
        check("t1_nreq", 16'(req_log.size()), 16'd4);
        check("t1_nt", log_at(0), 16'h2000);
        check("t1_at", log_at(1), 16'h23C0);
        check("t1_ptlo", log_at(2), 16'h0240);
        check("t1_pthi", log_at(3), 16'h0248);
        check("t1_tile_done", 16'(td_count), 16'd1);
        check("t1_overrun", {15'h0, overrun}, 16'h0000);
        check("t1_wr_req", {15'h0, mem_wr_request}, 16'h0000);

        // tile 2 moves tile-1 pattern into the high byte; tile 3 shows it
        for (int i = 0; i < 8; i++) dot(4);
        for (int i = 0; i < 8; i++) begin
            dot(4);
            check("px_fx0", {12'h0, bg_pixel}, (i % 2 == 1) ? 16'h2 : 16'h3);
        end

        // tile 4: new v and attribute byte, fine_x=1
        v_addr = 15'h0C63;
        at_val = 8'hC0;
        fine_x = 3'd1;
        req_log.delete();
        for (int i = 0; i < 8; i++) begin
            dot(4);
            check("px_fx1", {12'h0, bg_pixel}, (i % 2 == 1) ? 16'h3 : 16'h2);
        end
        check("t4_nt", log_at(0), 16'h2C63);
        check("t4_at", log_at(1), 16'h2FC0);
        check("t4_ptlo", log_at(2), 16'h0240);
        check("t4_pthi", log_at(3), 16'h0248);
        check("t4_tile_done", 16'(td_count), 16'd4);

        // attribute 3 from quadrant shift 6 reaches the pixel after reload
        dot(4);
        check("px_attr", {12'h0, bg_pixel}, 16'hE);

        // drop fetch_en at phase 4
        dot(4);
        dot(4);
        dot(4);
        fetch_en = 1'b0;
        req_log.delete();
        dot(4);
        check("px_hold0", {12'h0, bg_pixel}, 16'hE);
        dot(4);
        check("px_hold1", {12'h0, bg_pixel}, 16'hE);
        dot(4);
        dot(4);
        check("off_nreq", 16'(req_log.size()), 16'd0);
        check("off_tile_done", 16'(td_count), 16'd4);

        // re-enable: first fetch is NT
        fetch_en = 1'b1;
        dot(4);
        check("reen_nreq", 16'(req_log.size()), 16'd1);
        check("reen_nt", log_at(0), 16'h2C63);

        // reset while an AT read is outstanding
        dot(4);
        dot_tick = 1'b1;
        @(negedge clk);
        dot_tick = 1'b0;
        check("wait_req_hi", {15'h0, mem_read_request}, 16'h0001);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_req", {15'h0, mem_read_request}, 16'h0000);
        check("mrst_pixel", {12'h0, bg_pixel}, 16'h0000);
        check("mrst_addr", {2'b00, mem_addr}, 16'h0000);
        check("mrst_tile_done", {15'h0, tile_done}, 16'h0000);
        rst = 1'b1;
        req_log.delete();
        @(negedge clk);
        dot(4);
        check("mrst_phase_nreq", 16'(req_log.size()), 16'd1);
        check("mrst_phase_nt", log_at(0), 16'h2C63);

        // dots spaced 2 clks: overrun, captures still land
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ov_clear", {15'h0, overrun}, 16'h0000);
        nt_val = 8'h5A;
        req_log.delete();
        for (int i = 0; i < 6; i++) dot(2);
        check("ov_set", {15'h0, overrun}, 16'h0001);
        check("ov_nreq", 16'(req_log.size()), 16'd3);
        check("ov_nt", log_at(0), 16'h2C63);
        check("ov_at", log_at(1), 16'h2FC0);
        check("ov_ptlo", log_at(2), 16'h05A0);
        dot(4);
        dot(4);
        check("ov_sticky", {15'h0, overrun}, 16'h0001);
        check("ov_pthi", log_at(3), 16'h05A8);
        check("ov_tile_done", 16'(td_count), 16'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
